// File: rtl/demux8_4b_reg.sv
// Registered 1-to-8 demultiplexer for W-bit words: addressed or auto-pointer writes
// into eight slots, each with a valid flag, plus wrap-around pointer and sticky overflow.
module demux8_4b_reg #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         s2,
    input  logic         s1,
    input  logic         s0,
    input  logic [W-1:0] D,
    input  logic         we,
    input  logic         auto,
    input  logic         clr,
    output logic [W-1:0] Q0,
    output logic [W-1:0] Q1,
    output logic [W-1:0] Q2,
    output logic [W-1:0] Q3,
    output logic [W-1:0] Q4,
    output logic [W-1:0] Q5,
    output logic [W-1:0] Q6,
    output logic [W-1:0] Q7,
    output logic [7:0]   V,
    output logic [2:0]   ptr,
    output logic         full,
    output logic         ovf
);

    logic [W-1:0] q [8];
    logic [2:0]   dest;
    logic         reject;
    logic         accept;
    logic [7:0]   wr_en;

    // Address pins are ignored entirely in auto mode, so X on them cannot leak in.
    assign dest   = auto ? ptr : {s2, s1, s0};
    assign reject = auto && V[ptr];
    assign accept = we && !clr && !reject;

    always_comb begin
        wr_en = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            wr_en[i] = accept && (dest == 3'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < 8; i++) begin
                q[i] <= '0;
            end
            V   <= '0;
            ptr <= '0;
            ovf <= 1'b0;
        end else if (clr) begin
            V   <= '0;
            ptr <= '0;
            ovf <= 1'b0;
        end else if (we) begin
            if (reject) begin
                ovf <= 1'b1;
            end else begin
                for (int unsigned i = 0; i < 8; i++) begin
                    if (wr_en[i]) begin
                        q[i] <= D;
                        V[i] <= 1'b1;
                    end
                end
                if (auto) begin
                    ptr <= ptr + 3'd1;
                end
            end
        end
    end

    assign full = &V;

    assign Q0 = q[0];
    assign Q1 = q[1];
    assign Q2 = q[2];
    assign Q3 = q[3];
    assign Q4 = q[4];
    assign Q5 = q[5];
    assign Q6 = q[6];
    assign Q7 = q[7];

endmodule

// File: tb/tb_demux8_4b_reg.sv
// Self-checking bench for demux8_4b_reg: directed scenarios plus randomized traffic
// compared against an array-based behavioural model.
module tb_demux8_4b_reg;

    logic       clk;
    logic       reset;
    logic       s2, s1, s0;
    logic [3:0] D;
    logic       we, auto, clr;
    logic [3:0] Q0, Q1, Q2, Q3, Q4, Q5, Q6, Q7;
    logic [7:0] V;
    logic [2:0] ptr;
    logic       full, ovf;

    int errors = 0;
    int checks = 0;

    // behavioural model state
    logic [3:0] mq [8];
    bit         mv [8];
    int         mptr;
    bit         movf;

    demux8_4b_reg #(.W(4)) dut (
        .clk(clk), .reset(reset), .s2(s2), .s1(s1), .s0(s0), .D(D),
        .we(we), .auto(auto), .clr(clr),
        .Q0(Q0), .Q1(Q1), .Q2(Q2), .Q3(Q3), .Q4(Q4), .Q5(Q5), .Q6(Q6), .Q7(Q7),
        .V(V), .ptr(ptr), .full(full), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] dut_q(int i);
        case (i)
            0: return Q0;
            1: return Q1;
            2: return Q2;
            3: return Q3;
            4: return Q4;
            5: return Q5;
            6: return Q6;
            default: return Q7;
        endcase
    endfunction

    function automatic logic [7:0] model_v();
        logic [7:0] r = '0;
        for (int i = 0; i < 8; i++) if (mv[i]) r[i] = 1'b1;
        return r;
    endfunction

    function automatic bit model_full();
        for (int i = 0; i < 8; i++) if (!mv[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic void model_apply(bit r, bit c, bit w, bit a, int addr, logic [3:0] d);
        int dst;
        if (r) begin
            for (int i = 0; i < 8; i++) begin mq[i] = 4'h0; mv[i] = 0; end
            mptr = 0;
            movf = 0;
        end else if (c) begin
            for (int i = 0; i < 8; i++) mv[i] = 0;
            mptr = 0;
            movf = 0;
        end else if (w) begin
            dst = a ? mptr : addr;
            if (a && mv[dst]) begin
                movf = 1;
            end else begin
                mq[dst] = d;
                mv[dst] = 1;
                if (a) mptr = (mptr + 1) % 8;
            end
        end
    endfunction

    // Apply one clock edge of stimulus, advance the model, sample 1 time unit after the edge.
    task automatic drive(bit r, bit c, bit w, bit a, int addr, logic [3:0] d);
        logic [2:0] ab;
        ab    = 3'(addr);
        reset = r; clr = c; we = w; auto = a; D = d;
        {s2, s1, s0} = ab;
        @(posedge clk);
        model_apply(r, c, w, a, addr, d);
        #1;
        reset = 0; clr = 0; we = 0; auto = 0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) drive(0, 0, 1, 1, 0, 4'($urandom_range(1, 15)));
        drive(0, 0, 1, 0, 6, 4'hB);
        drive(1, 0, 0, 0, 0, 4'h0);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (dut_q(i) !== 4'h0) begin
                errors++; $display("FAIL reset_q%0d: got %h expected 0", i, dut_q(i));
            end
        end
        checks++;
        if (V !== 8'h00) begin errors++; $display("FAIL reset_v: got %h expected 00", V); end
        checks++;
        if (ptr !== 3'd0) begin errors++; $display("FAIL reset_ptr: got %0d expected 0", ptr); end
        checks++;
        if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
        checks++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
    endtask

    task automatic test_addressed();
        drive(1, 0, 0, 0, 0, 4'h0);
        drive(0, 0, 1, 0, 5, 4'hA);
        checks++;
        if (Q5 !== 4'hA) begin errors++; $display("FAIL addr_q5_first: got %h expected a", Q5); end
        drive(0, 0, 1, 0, 5, 4'h3);
        checks++;
        if (Q5 !== 4'h3) begin errors++; $display("FAIL addr_q5_second: got %h expected 3", Q5); end
        checks++;
        if (V !== 8'h20) begin errors++; $display("FAIL addr_v: got %h expected 20", V); end
        for (int i = 0; i < 8; i++) begin
            if (i == 5) continue;
            checks++;
            if (dut_q(i) !== 4'h0) begin
                errors++; $display("FAIL addr_other_q%0d: got %h expected 0", i, dut_q(i));
            end
        end
        checks++;
        if (ptr !== 3'd0) begin errors++; $display("FAIL addr_ptr: got %0d expected 0", ptr); end
    endtask

    task automatic test_auto_wrap();
        drive(1, 0, 0, 0, 0, 4'h0);
        for (int i = 0; i < 8; i++) begin
            drive(0, 0, 1, 1, $urandom_range(0, 7), 4'(i + 1));
            checks++;
            if (ptr !== 3'((i + 1) % 8)) begin
                errors++; $display("FAIL auto_ptr_step%0d: got %0d expected %0d", i, ptr, (i + 1) % 8);
            end
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (dut_q(i) !== 4'(i + 1)) begin
                errors++; $display("FAIL auto_q%0d: got %h expected %h", i, dut_q(i), 4'(i + 1));
            end
        end
        checks++;
        if (V !== 8'hFF) begin errors++; $display("FAIL auto_v: got %h expected ff", V); end
        checks++;
        if (full !== 1'b1) begin errors++; $display("FAIL auto_full: got %b expected 1", full); end
        checks++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL auto_ovf_before: got %b expected 0", ovf); end
        drive(0, 0, 1, 1, 0, 4'hF);
        checks++;
        if (Q0 !== 4'h1) begin errors++; $display("FAIL auto_reject_q0: got %h expected 1", Q0); end
        checks++;
        if (ovf !== 1'b1) begin errors++; $display("FAIL auto_reject_ovf: got %b expected 1", ovf); end
        checks++;
        if (ptr !== 3'd0) begin errors++; $display("FAIL auto_reject_ptr: got %0d expected 0", ptr); end
        drive(0, 0, 0, 0, 3, 4'h6);
        checks++;
        if (ovf !== 1'b1) begin errors++; $display("FAIL auto_ovf_sticky: got %b expected 1", ovf); end
    endtask

    task automatic test_mixed();
        drive(1, 0, 0, 0, 0, 4'h0);
        drive(0, 0, 1, 0, 0, 4'h7);
        drive(0, 0, 1, 1, 4, 4'h9);
        checks++;
        if (ovf !== 1'b1) begin errors++; $display("FAIL mixed_ovf: got %b expected 1", ovf); end
        checks++;
        if (ptr !== 3'd0) begin errors++; $display("FAIL mixed_ptr: got %0d expected 0", ptr); end
        checks++;
        if (Q0 !== 4'h7) begin errors++; $display("FAIL mixed_q0: got %h expected 7", Q0); end
        checks++;
        if (V !== 8'h01) begin errors++; $display("FAIL mixed_v: got %h expected 01", V); end
    endtask

    task automatic test_clr_vs_write();
        drive(1, 0, 0, 0, 0, 4'h0);
        for (int i = 0; i < 8; i++) drive(0, 0, 1, 1, 0, 4'(8 - i));
        drive(0, 0, 1, 1, 0, 4'h0);
        checks++;
        if (V !== 8'hFF || ovf !== 1'b1) begin
            errors++; $display("FAIL clr_setup: got v=%h ovf=%b expected v=ff ovf=1", V, ovf);
        end
        drive(0, 1, 1, 0, 2, 4'hC);
        checks++;
        if (V !== 8'h00) begin errors++; $display("FAIL clr_v: got %h expected 00", V); end
        checks++;
        if (ptr !== 3'd0) begin errors++; $display("FAIL clr_ptr: got %0d expected 0", ptr); end
        checks++;
        if (ovf !== 1'b0) begin errors++; $display("FAIL clr_ovf: got %b expected 0", ovf); end
        checks++;
        if (Q2 !== 4'h6) begin errors++; $display("FAIL clr_q2_kept: got %h expected 6", Q2); end
        checks++;
        if (full !== 1'b0) begin errors++; $display("FAIL clr_full: got %b expected 0", full); end
        drive(0, 0, 1, 1, 0, 4'hD);
        checks++;
        if (Q0 !== 4'hD || ptr !== 3'd1) begin
            errors++; $display("FAIL clr_then_auto: got q0=%h ptr=%0d expected q0=d ptr=1", Q0, ptr);
        end
    endtask

    task automatic test_reset_priority();
        drive(0, 0, 1, 0, 3, 4'h5);
        drive(0, 0, 1, 1, 0, 4'h8);
        drive(1, 1, 1, 0, 4, 4'hE);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (dut_q(i) !== 4'h0) begin
                errors++; $display("FAIL prio_q%0d: got %h expected 0", i, dut_q(i));
            end
        end
        checks++;
        if (V !== 8'h00 || ptr !== 3'd0 || ovf !== 1'b0 || full !== 1'b0) begin
            errors++;
            $display("FAIL prio_state: got v=%h ptr=%0d ovf=%b full=%b expected all 0", V, ptr, ovf, full);
        end
    endtask

    task automatic test_random();
        bit r, c, w, a;
        drive(1, 0, 0, 0, 0, 4'h0);
        for (int n = 0; n < 400; n++) begin
            r = ($urandom_range(0, 99) < 2);
            c = ($urandom_range(0, 99) < 4);
            w = ($urandom_range(0, 99) < 80);
            a = ($urandom_range(0, 99) < 60);
            drive(r, c, w, a, $urandom_range(0, 7), 4'($urandom));
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (dut_q(i) !== mq[i]) begin
                    errors++; $display("FAIL rand_q%0d cyc %0d: got %h expected %h", i, n, dut_q(i), mq[i]);
                end
            end
            checks++;
            if (V !== model_v()) begin
                errors++; $display("FAIL rand_v cyc %0d: got %h expected %h", n, V, model_v());
            end
            checks++;
            if (ptr !== 3'(mptr)) begin
                errors++; $display("FAIL rand_ptr cyc %0d: got %0d expected %0d", n, ptr, mptr);
            end
            checks++;
            if (full !== model_full()) begin
                errors++; $display("FAIL rand_full cyc %0d: got %b expected %b", n, full, model_full());
            end
            checks++;
            if (ovf !== movf) begin
                errors++; $display("FAIL rand_ovf cyc %0d: got %b expected %b", n, ovf, movf);
            end
        end
    endtask

    initial begin
        reset = 0; clr = 0; we = 0; auto = 0; D = '0;
        {s2, s1, s0} = 3'b000;
        for (int i = 0; i < 8; i++) begin mq[i] = 4'h0; mv[i] = 0; end
        mptr = 0;
        movf = 0;
        drive(1, 0, 0, 0, 0, 4'h0);
        test_reset();
        test_addressed();
        test_auto_wrap();
        test_mixed();
        test_clr_vs_write();
        test_reset_priority();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/demux8_4b_reg.md
# demux8_4b_reg

Registered 1-to-8 demultiplexer for 4-bit words. It is the write side of the 8-way, 4-bit word selector used in the datapath. A single 4-bit input is steered either to an explicitly addressed slot or to the next slot from an internal auto-increment pointer. Each slot holds its word and a valid flag until cleared. The registered slot outputs feed the eight word inputs of the 8:1 selector directly.

## Interface
Parameters:
- W, default 4, width of each word and slot.

Ports:
- clk  input  1  rising-edge clock for all state.
- reset  input  1  synchronous, active-high; clears all state on a rising clk edge where reset=1.
- s2, s1, s0  input  1 each  slot address {s2,s1,s0} for addressed writes.
- D  input  W  write data.
- we  input  1  write strobe; one write per clk edge where we=1.
- auto  input  1  1 = destination is the internal pointer; 0 = destination is {s2,s1,s0}.
- clr  input  1  clears valid flags, pointer and overflow; Q contents are kept.
- Q0..Q7  output  W each  slot registers.
- V  output  8  per-slot valid flags; V[i] belongs to Qi.
- ptr  output  3  current auto-mode destination slot.
- full  output  1  &V, combinational from registered V.
- ovf  output  1  sticky; set by a rejected auto-mode write.

## Operation
Reset is evaluated first each edge. When reset=1: Q0..Q7=0, V=8'h00, ptr=0, ovf=0, so full=0. Reset overrides clr and we.

clr=1 (reset=0):
- V=0, ptr=0, ovf=0.
- Q0..Q7 hold their values.
- Any write in the same cycle is dropped.

Addressed write (we=1, auto=0, clr=0, reset=0):
- dest={s2,s1,s0}.
- Qdest<=D, V[dest]<=1.
- Always accepted, overwriting any prior valid word.
- ptr and ovf unchanged.

Auto write (we=1, auto=1, clr=0, reset=0):
- dest=ptr.
- If V[ptr]=0: Qptr<=D, V[ptr]<=1, ptr<=ptr+1 mod 8 (7 wraps to 0).
- If V[ptr]=1: write rejected. No Q, V or ptr change; ovf<=1.

we=0: all state holds.

Other rules:
- Only the destination slot may change on a write; the other seven slots must never glitch or update.
- ovf clears only on reset or clr.
- Mixing modes is legal. An addressed write to slot ptr makes the next auto write reject.
- X/Z on s2..s0 while auto=1 or we=0 has no effect.

## Timing
- Write latency: Q, V, ptr and ovf reflect a write one edge after it is sampled.
- full changes in the same cycle V changes, with no extra register stage.
- No back-pressure handshake. The producer must check full, or V[ptr], before an auto write. A rejected write is reported only through ovf, visible the cycle after.
- Simultaneous events, highest priority first: reset > clr > we.
- Reset mid-sequence: state cleared at that edge. The first write after reset deasserts goes to slot 0 in auto mode.
- Throughput: one write per cycle sustained, including back-to-back auto writes across the 7->0 wrap.

## Test plan
- Reset: drive Q/V to nonzero, assert reset for 1 edge -> all Q=0, V=00, ptr=0, full=0, ovf=0 on the next cycle.
- Addressed writes: write D=4'hA to slot 5, then D=4'h3 to slot 5 -> Q5=A then 3; V=8'h20. All other Q stay 0. ptr stays 0.
- Auto fill with wrap: 8 back-to-back auto writes D=1..8 -> Q0..Q7=1..8, V=FF, full=1, ptr=0 (wrapped). A 9th auto write D=F -> rejected, Q0 still 1, ovf=1.
- Mixed mode: reset; addressed write slot 0 D=7; auto write D=9 -> rejected (V[0]=1), ovf=1, ptr=0.
- clr vs write: with V=FF, ovf=1, assert clr and we (addressed slot 2, D=C) together -> V=00, ptr=0, ovf=0, Q2 keeps its old value, full=0.
- Reset priority: reset=1, clr=1 and we=1 in the same cycle -> reset result only (all zero); no write lands.
